// File: rtl/score_tally.sv
// score_tally: game-level scorekeeper fed by the per-lane arrow droppers.
//
// Collects the dropper score flags, turns their rising edges into hits and
// keeps score (saturating at SCORE_MAX), combo, max combo and hit count while
// running the Idle -> Play -> Done game sequence from the shared keycode.
//
// Ports:
//   frame_clk    in   1        frame-rate clock (vsync)
//   Reset        in   1        synchronous, active-high
//   keycode      in   8        8'h2c starts a game, 8'h01 restarts after Done
//   score_vec    in   N_DROPS  dropper score flags (levels)
//   score_bcd    out  16       4-digit BCD of the score
//   combo        out  8        current combo
//   max_combo    out  8        best combo this game
//   hit_count    out  8        hits this game, saturating at 255
//   playing      out  1        high in Play
//   game_over    out  1        high in Done
//   hiscore_bcd  out  16       BCD high score (0 unless SCORE_TALLY_HISCORE_EN)
//
// Build option: define SCORE_TALLY_HISCORE_EN to keep a high score that
// survives restarts (cleared only by Reset).

module score_tally #(
    parameter int unsigned N_DROPS       = 32,
    parameter int unsigned SONG_FRAMES   = 2400,
    parameter int unsigned COMBO_TIMEOUT = 90,
    parameter int unsigned BONUS_THRESH  = 10,
    parameter int unsigned SCORE_MAX     = 9999
) (
    input  logic               frame_clk,
    input  logic               Reset,
    input  logic [7:0]         keycode,
    input  logic [N_DROPS-1:0] score_vec,
    output logic [15:0]        score_bcd,
    output logic [7:0]         combo,
    output logic [7:0]         max_combo,
    output logic [7:0]         hit_count,
    output logic               playing,
    output logic               game_over,
    output logic [15:0]        hiscore_bcd
);

    localparam int unsigned CW = $clog2(N_DROPS + 1);
    localparam int unsigned FW = $clog2(SONG_FRAMES + 1);
    localparam int unsigned TW = $clog2(COMBO_TIMEOUT + 1);
    localparam logic [7:0] KEY_START   = 8'h2c;
    localparam logic [7:0] KEY_RESTART = 8'h01;

    typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

    state_t             state, state_next;
    logic [13:0]        score, score_next;
    logic [7:0]         combo_next, max_next, hits_next;
    logic [FW-1:0]      frame_cnt, frame_next;
    logic [TW-1:0]      to_cnt, to_next;
    logic [N_DROPS-1:0] prev_vec, new_hits;
    logic [CW-1:0]      n_hits;
    logic [CW:0]        add_amt;
    logic [14:0]        score_sum;
    logic [15:0]        combo_sum, hits_sum;

    function automatic logic [15:0] bin2bcd(input logic [13:0] bin);
        logic [15:0] bcd;
        bcd = '0;
        for (int unsigned i = 0; i < 14; i++) begin
            for (int unsigned d = 0; d < 4; d++) begin
                if (bcd[4*d +: 4] >= 4'd5)
                    bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
            end
            bcd = {bcd[14:0], bin[13-i]};
        end
        return bcd;
    endfunction

    // Only rising edges are hits; a flag dropping back to 0 just re-arms it.
    always_comb begin
        new_hits = score_vec & ~prev_vec;
        n_hits   = '0;
        for (int unsigned i = 0; i < N_DROPS; i++)
            n_hits = n_hits + CW'(new_hits[i]);
    end

    always_comb begin
        state_next = state;
        score_next = score;
        combo_next = combo;
        max_next   = max_combo;
        hits_next  = hit_count;
        frame_next = frame_cnt;
        to_next    = to_cnt;

        // Bonus decision uses the combo from before this frame's hits.
        add_amt   = (combo >= 8'(BONUS_THRESH)) ? {n_hits, 1'b0} : {1'b0, n_hits};
        score_sum = 15'(score) + 15'(add_amt);
        combo_sum = 16'(combo) + 16'(n_hits);
        hits_sum  = 16'(hit_count) + 16'(n_hits);

        case (state)
            IDLE: begin
                score_next = '0;
                combo_next = '0;
                max_next   = '0;
                hits_next  = '0;
                frame_next = '0;
                to_next    = '0;
                if (keycode == KEY_START)
                    state_next = PLAY;
            end
            PLAY: begin
                score_next = (score_sum > 15'(SCORE_MAX)) ? 14'(SCORE_MAX) : score_sum[13:0];
                if (n_hits != '0) begin
                    combo_next = (combo_sum > 16'd255) ? 8'hff : combo_sum[7:0];
                    to_next    = '0;
                end else if (to_cnt == TW'(COMBO_TIMEOUT - 1)) begin
                    combo_next = '0;
                    to_next    = '0;
                end else begin
                    to_next = to_cnt + TW'(1);
                end
                max_next   = (combo_next > max_combo) ? combo_next : max_combo;
                hits_next  = (hits_sum > 16'd255) ? 8'hff : hits_sum[7:0];
                frame_next = frame_cnt + FW'(1);
                if (frame_cnt == FW'(SONG_FRAMES - 1))
                    state_next = DONE;
            end
            DONE: begin
                // Tallies clear on the restart edge so Idle is entered at zero.
                if (keycode == KEY_RESTART) begin
                    state_next = IDLE;
                    score_next = '0;
                    combo_next = '0;
                    max_next   = '0;
                    hits_next  = '0;
                    frame_next = '0;
                    to_next    = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state     <= IDLE;
            score     <= '0;
            combo     <= '0;
            max_combo <= '0;
            hit_count <= '0;
            frame_cnt <= '0;
            to_cnt    <= '0;
            prev_vec  <= '0;
            playing   <= 1'b0;
            game_over <= 1'b0;
        end else begin
            state     <= state_next;
            score     <= score_next;
            combo     <= combo_next;
            max_combo <= max_next;
            hit_count <= hits_next;
            frame_cnt <= frame_next;
            to_cnt    <= to_next;
            prev_vec  <= score_vec;
            playing   <= (state_next == PLAY);
            game_over <= (state_next == DONE);
        end
    end

    assign score_bcd = bin2bcd(score);

`ifdef SCORE_TALLY_HISCORE_EN
    logic [13:0] hiscore;

    // Captured on Play->Done so the final frame's hits are included.
    always_ff @(posedge frame_clk) begin
        if (Reset)
            hiscore <= '0;
        else if (state == PLAY && state_next == DONE && score_next > hiscore)
            hiscore <= score_next;
    end

    assign hiscore_bcd = bin2bcd(hiscore);
`else
    assign hiscore_bcd = 16'h0000;
`endif

endmodule

// File: tb/tb_score_tally.sv
module tb_score_tally;

  logic        frame_clk;
  logic        Reset;
  logic [7:0]  keycode;
  logic [31:0] score_vec;
  logic [15:0] score_bcd;
  logic [7:0]  combo;
  logic [7:0]  max_combo;
  logic [7:0]  hit_count;
  logic        playing;
  logic        game_over;
  logic [15:0] hiscore_bcd;

  score_tally #(
    .N_DROPS      (32),
    .SONG_FRAMES  (2400),
    .COMBO_TIMEOUT(90),
    .BONUS_THRESH (10),
    .SCORE_MAX    (9999)
  ) dut (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .keycode    (keycode),
    .score_vec  (score_vec),
    .score_bcd  (score_bcd),
    .combo      (combo),
    .max_combo  (max_combo),
    .hit_count  (hit_count),
    .playing    (playing),
    .game_over  (game_over),
    .hiscore_bcd(hiscore_bcd)
  );

`ifdef SCORE_TALLY_HISCORE_EN
  localparam logic [15:0] HI1 = 16'h0020;
`else
  localparam logic [15:0] HI1 = 16'h0000;
`endif

  typedef struct packed {
    logic [31:0] at;
    logic [15:0] sbcd;
    logic [7:0]  combo;
    logic [7:0]  maxc;
    logic [7:0]  hits;
    logic        play;
    logic        over;
    logic [15:0] hi;
  } exp_t;

  exp_t  q[$];
  string tq[$];
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned p = 0;
  logic [31:0] vec;

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  always @(posedge frame_clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    checks++;
    errors++;
    $display("FAIL watchdog: stimulus did not complete in time (cyc=%0d)", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  always @(negedge frame_clk) begin
    exp_t  e;
    string tag;
    while (q.size() > 0 && q[0].at <= cyc) begin
      e   = q.pop_front();
      tag = tq.pop_front();
      checks++;
      if (e.at != cyc) begin
        errors++;
        $display("FAIL %s sampled late: cyc=%0d due=%0d", tag, cyc, e.at);
      end else if (score_bcd !== e.sbcd || combo !== e.combo ||
                   max_combo !== e.maxc || hit_count !== e.hits || playing !== e.play ||
                   game_over !== e.over || hiscore_bcd !== e.hi) begin
        errors++;
        $display("FAIL %s cyc=%0d got score_bcd=%h combo=%0d max=%0d hits=%0d play=%b over=%b hi=%h want score_bcd=%h combo=%0d max=%0d hits=%0d play=%b over=%b hi=%h",
                 tag, cyc, score_bcd, combo, max_combo, hit_count, playing,
                 game_over, hiscore_bcd, e.sbcd, e.combo, e.maxc, e.hits, e.play,
                 e.over, e.hi);
      end
    end
  end

  task automatic step(input logic [7:0] k, input logic [31:0] v);
    keycode   = k;
    score_vec = v;
    @(posedge frame_clk);
    #1;
    p++;
  endtask

  task automatic chk(input string tag, input logic [15:0] sbcd, input logic [7:0] c,
                     input logic [7:0] m, input logic [7:0] h, input logic pl,
                     input logic ov, input logic [15:0] hi);
    exp_t e;
    e.at = cyc; e.sbcd = sbcd; e.combo = c; e.maxc = m; e.hits = h;
    e.play = pl; e.over = ov; e.hi = hi;
    q.push_back(e);
    tq.push_back(tag);
  endtask

  initial begin
    Reset = 1'b1;
    vec   = 32'h0000_0020;
    step(8'h00, vec);
    step(8'h00, vec);
    checks++;
    if (score_bcd !== 16'h0000 || combo !== 8'd0 || max_combo !== 8'd0 ||
        hit_count !== 8'd0 || playing !== 1'b0 || game_over !== 1'b0 ||
        hiscore_bcd !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state got score_bcd=%h combo=%0d max=%0d hits=%0d play=%b over=%b hi=%h",
               score_bcd, combo, max_combo, hit_count, playing, game_over, hiscore_bcd);
    end
    chk("reset", 16'h0000, 0, 0, 0, 0, 0, 16'h0000);
    Reset = 1'b0;
    step(8'h00, vec);
    chk("idle", 16'h0000, 0, 0, 0, 0, 0, 16'h0000);

    step(8'h2c, vec);
    chk("start", 16'h0000, 0, 0, 0, 1, 0, 16'h0000);
    p = 0;

    step(8'h01, vec);
    chk("no_spurious", 16'h0000, 0, 0, 0, 1, 0, 16'h0000);

    vec = vec | 32'h0000_0089;
    step(8'h00, vec);
    chk("multi", 16'h0003, 3, 3, 3, 1, 0, 16'h0000);

    for (int i = 8; i <= 14; i++) begin
      vec[i] = 1'b1;
      step(8'h00, vec);
    end
    chk("combo10", 16'h0010, 10, 10, 10, 1, 0, 16'h0000);

    vec[15] = 1'b1;
    step(8'h2c, vec);
    chk("bonus", 16'h0012, 11, 11, 11, 1, 0, 16'h0000);

    vec[17:16] = 2'b11;
    step(8'h00, vec);
    chk("bonus2", 16'h0016, 13, 13, 13, 1, 0, 16'h0000);

    vec[16] = 1'b0;
    step(8'h00, vec);
    chk("fall", 16'h0016, 13, 13, 13, 1, 0, 16'h0000);

    vec[16] = 1'b1;
    step(8'h00, vec);
    chk("rerise", 16'h0018, 14, 14, 14, 1, 0, 16'h0000);

    repeat (89) step(8'h00, vec);
    chk("pre_timeout", 16'h0018, 14, 14, 14, 1, 0, 16'h0000);
    step(8'h00, vec);
    chk("timeout", 16'h0018, 0, 14, 14, 1, 0, 16'h0000);

    vec[18] = 1'b1;
    step(8'h00, vec);
    chk("post_timeout", 16'h0019, 1, 14, 15, 1, 0, 16'h0000);

    while (p < 2399) step(8'h00, vec);
    chk("pre_end", 16'h0019, 0, 14, 15, 1, 0, 16'h0000);

    vec[19] = 1'b1;
    step(8'h00, vec);
    chk("done", 16'h0020, 1, 14, 16, 0, 1, HI1);

    vec[20] = 1'b1;
    step(8'h2c, vec);
    chk("frozen", 16'h0020, 1, 14, 16, 0, 1, HI1);

    step(8'h01, vec);
    chk("restart", 16'h0000, 0, 0, 0, 0, 0, HI1);
    vec = 32'h0;
    step(8'h01, vec);
    chk("idle_01", 16'h0000, 0, 0, 0, 0, 0, HI1);

    step(8'h2c, vec);
    chk("start2", 16'h0000, 0, 0, 0, 1, 0, HI1);

    step(8'h00, 32'hffff_ffff);
    chk("all_rise", 16'h0032, 32, 32, 32, 1, 0, HI1);
    step(8'h00, 32'h0);
    repeat (159) begin
      step(8'h00, 32'hffff_ffff);
      step(8'h00, 32'h0);
    end
    chk("saturate", 16'h9999, 255, 255, 255, 1, 0, HI1);

    Reset = 1'b1;
    step(8'h2c, 32'hffff_ffff);
    chk("mid_reset", 16'h0000, 0, 0, 0, 0, 0, 16'h0000);
    Reset = 1'b0;
    step(8'h00, 32'hffff_ffff);
    chk("after_reset", 16'h0000, 0, 0, 0, 0, 0, 16'h0000);

    repeat (3) @(posedge frame_clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending: %0d expectation(s) never compared", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
